// File: rtl/eth_udp_rx.sv
// Receive-side Ethernet/IPv4/UDP filter: parses each frame byte by byte and forwards
// the UDP payload of datagrams addressed to this station on a small range of ports.
module eth_udp_rx #(
  parameter logic [47:0] FPGA_MAC     = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [31:0] FPGA_IP      = 32'hC0_00_02_92,
  parameter logic [15:0] PORT_BASE    = 16'd5005,
  parameter int          NUM_PORTS    = 4,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_start,
  input  logic        rx_end,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic [3:0]  m_chan,
  output logic        m_abort,
  output logic [15:0] accept_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, DRAIN} state_t;

  localparam logic [16:0] PORT_END = {1'b0, PORT_BASE} + 17'(NUM_PORTS);

  function automatic logic [7:0] mac_byte(input logic [2:0] idx);
    logic [47:0] sh;
    sh = FPGA_MAC << {idx, 3'b000};
    return sh[47:40];
  endfunction

  function automatic logic [7:0] ip_byte(input logic [1:0] idx);
    logic [31:0] sh;
    sh = FPGA_IP << {idx, 3'b000};
    return sh[31:24];
  endfunction

  // One's-complement add; a single end-around fold is enough for two 16-bit operands.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic        mac_ok_r, bc_ok_r, type_ok_r;
  logic        ver_ok_r, frag_ok_r, proto_ok_r, dip_ok_r;
  logic [3:0]  ihl_r;
  logic [15:0] total_len_r, csum_r, dport_r, ulen_r, remain_r;
  logic [7:0]  hi_r;

  logic [15:0] word_sum_s, chan_full_s;
  logic        ip_last_s, dip_ok_s, ip_pass_s, udp_pass_s;

  // Decisions taken on the byte currently presented, before it is registered.
  always_comb begin
    word_sum_s  = csum_add(csum_r, {hi_r, rx_byte});
    ip_last_s   = (cnt_r != 6'd0) && (cnt_r == {ihl_r - 4'd1, 2'b11});
    dip_ok_s    = dip_ok_r && !((cnt_r[5:2] == 4'd4) && (rx_byte != ip_byte(cnt_r[1:0])));
    ip_pass_s   = ver_ok_r && (ihl_r >= 4'd5) && proto_ok_r && frag_ok_r && dip_ok_s &&
                  (word_sum_s == 16'hFFFF);
    udp_pass_s  = (dport_r >= PORT_BASE) && ({1'b0, dport_r} < PORT_END) &&
                  (ulen_r >= 16'd8) &&
                  (({1'b0, ulen_r} + {11'd0, ihl_r, 2'b00}) <= {1'b0, total_len_r});
    chan_full_s = dport_r - PORT_BASE;
  end

  // Parser FSM, header field capture, output beats and statistics counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      cnt_r       <= 6'd0;
      mac_ok_r    <= 1'b0;
      bc_ok_r     <= 1'b0;
      type_ok_r   <= 1'b0;
      ver_ok_r    <= 1'b0;
      frag_ok_r   <= 1'b0;
      proto_ok_r  <= 1'b0;
      dip_ok_r    <= 1'b0;
      ihl_r       <= 4'd0;
      total_len_r <= 16'd0;
      csum_r      <= 16'd0;
      dport_r     <= 16'd0;
      ulen_r      <= 16'd0;
      remain_r    <= 16'd0;
      hi_r        <= 8'd0;
      m_data      <= 8'd0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_chan      <= 4'd0;
      m_abort     <= 1'b0;
      accept_cnt  <= 16'd0;
      drop_cnt    <= 16'd0;
    end else begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_abort <= 1'b0;
      if (rx_valid && rx_start) begin
        if (state_r == PAYLOAD) begin
          m_abort  <= 1'b1;
          drop_cnt <= sat_inc(drop_cnt);
        end
        state_r  <= ETH_HDR;
        cnt_r    <= 6'd1;
        mac_ok_r <= (rx_byte == mac_byte(3'd0));
        bc_ok_r  <= ACCEPT_BCAST && (rx_byte == 8'hFF);
      end else begin
        case (state_r)
          IDLE: begin
            cnt_r <= 6'd0;
          end
          ETH_HDR: begin
            if (rx_valid) begin
              cnt_r <= cnt_r + 6'd1;
              if (cnt_r < 6'd6) begin
                mac_ok_r <= mac_ok_r && (rx_byte == mac_byte(cnt_r[2:0]));
                bc_ok_r  <= bc_ok_r && (rx_byte == 8'hFF);
              end
              if (cnt_r == 6'd12) type_ok_r <= (rx_byte == 8'h08);
              if (cnt_r == 6'd13) begin
                if ((mac_ok_r || bc_ok_r) && type_ok_r && (rx_byte == 8'h00)) begin
                  state_r  <= IP_HDR;
                  cnt_r    <= 6'd0;
                  csum_r   <= 16'd0;
                  dip_ok_r <= 1'b1;
                end else begin
                  state_r <= DRAIN;
                end
              end
            end
          end
          IP_HDR: begin
            if (rx_valid) begin
              cnt_r    <= cnt_r + 6'd1;
              dip_ok_r <= dip_ok_s;
              if (cnt_r[0]) csum_r <= word_sum_s;
              else          hi_r   <= rx_byte;
              if (cnt_r == 6'd0) begin
                ver_ok_r <= (rx_byte[7:4] == 4'd4);
                ihl_r    <= rx_byte[3:0];
              end
              if (cnt_r == 6'd2) total_len_r[15:8] <= rx_byte;
              if (cnt_r == 6'd3) total_len_r[7:0]  <= rx_byte;
              // Byte 6 carries MF and the top of the fragment offset; both must be clear.
              if (cnt_r == 6'd6) frag_ok_r  <= (rx_byte[5:0] == 6'd0);
              if (cnt_r == 6'd7) frag_ok_r  <= frag_ok_r && (rx_byte == 8'd0);
              if (cnt_r == 6'd9) proto_ok_r <= (rx_byte == 8'd17);
              if (ip_last_s) begin
                if (ip_pass_s) begin
                  state_r <= UDP_HDR;
                  cnt_r   <= 6'd0;
                end else begin
                  state_r  <= DRAIN;
                  drop_cnt <= sat_inc(drop_cnt);
                end
              end
            end
          end
          UDP_HDR: begin
            if (rx_valid) begin
              cnt_r <= cnt_r + 6'd1;
              if (cnt_r == 6'd2) dport_r[15:8] <= rx_byte;
              if (cnt_r == 6'd3) dport_r[7:0]  <= rx_byte;
              if (cnt_r == 6'd4) ulen_r[15:8]  <= rx_byte;
              if (cnt_r == 6'd5) ulen_r[7:0]   <= rx_byte;
              if (cnt_r == 6'd7) begin
                if (!udp_pass_s) begin
                  state_r  <= DRAIN;
                  drop_cnt <= sat_inc(drop_cnt);
                end else if (ulen_r == 16'd8) begin
                  state_r    <= DRAIN;
                  accept_cnt <= sat_inc(accept_cnt);
                end else begin
                  state_r  <= PAYLOAD;
                  m_chan   <= chan_full_s[3:0];
                  remain_r <= ulen_r - 16'd8;
                end
              end
            end
          end
          PAYLOAD: begin
            if (rx_valid) begin
              m_data   <= rx_byte;
              m_valid  <= 1'b1;
              remain_r <= remain_r - 16'd1;
              if (remain_r == 16'd1) begin
                m_last     <= 1'b1;
                accept_cnt <= sat_inc(accept_cnt);
                state_r    <= DRAIN;
              end
            end
          end
          DRAIN: begin
            cnt_r <= 6'd0;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
        // Carrier drop: a byte arriving with it was already handled above.
        if (rx_end) begin
          if ((state_r == PAYLOAD) && !(rx_valid && (remain_r == 16'd1))) begin
            m_abort  <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
          end
          state_r <= IDLE;
        end
      end
    end
  end

endmodule

// File: doc/eth_udp_rx.md
ETH_UDP_RX -- requirements
Module: eth_udp_rx

Interface
REQ-001 SHALL have parameter FPGA_MAC, default 48'h00_1A_2B_3C_4D_5E, station MAC.
REQ-002 SHALL have parameter FPGA_IP, default 32'hC0_00_02_92, station IPv4 address.
REQ-003 SHALL have parameter PORT_BASE, default 16'd5005, first accepted UDP destination port.
REQ-004 SHALL have parameter NUM_PORTS, default 4, range 1..16, count of consecutive accepted ports.
REQ-005 SHALL have parameter ACCEPT_BCAST, default 1, when 1 also accept dest MAC FF:FF:FF:FF:FF:FF.
REQ-006 SHALL have port clk  input  1  RX byte clock; all logic on rising edge.
REQ-007 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port rx_byte  input  8  received byte, valid when rx_valid=1.
REQ-009 SHALL have port rx_valid  input  1  one-cycle strobe per byte.
REQ-010 SHALL have port rx_start  input  1  pulse coincident with the first byte after SFD (dest MAC byte 0).
REQ-011 SHALL have port rx_end  input  1  pulse when the frame terminates (carrier drop).
REQ-012 SHALL have port m_data  output  8  payload byte.
REQ-013 SHALL have port m_valid  output  1  m_data valid this cycle.
REQ-014 SHALL have port m_last  output  1  high with the final payload byte.
REQ-015 SHALL have port m_chan  output  4  port index (dest_port - PORT_BASE), stable for whole datagram.
REQ-016 SHALL have port m_abort  output  1  one-cycle pulse: delivered datagram truncated.
REQ-017 SHALL have port accept_cnt  output  16  datagrams fully delivered, saturating.
REQ-018 SHALL have port drop_cnt  output  16  MAC/ethertype-matched frames rejected or aborted, saturating.

Function
REQ-019 SHALL implement states IDLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, DRAIN; rx_start with rx_valid from any state enters ETH_HDR, byte counted as dest MAC byte 0.
REQ-020 ETH_HDR SHALL capture 14 bytes; at byte 13 go IP_HDR if dest MAC = FPGA_MAC (or broadcast with ACCEPT_BCAST=1) and ethertype = 0x0800, else DRAIN without drop_cnt increment.
REQ-021 IP_HDR SHALL length IHL*4 bytes (IHL from byte 0 low nibble); options bytes consumed and checksummed, not stored.
REQ-022 At final IP header byte SHALL require: version 4, IHL >= 5, protocol 17, MF=0, frag_offset=0, dest IP = FPGA_IP, ones-complement 16-bit sum of all header words (current byte included, carries end-around folded) = 0xFFFF; pass -> UDP_HDR, fail -> DRAIN with drop_cnt+1.
REQ-023 At UDP byte 7 SHALL require PORT_BASE <= dest_port < PORT_BASE+NUM_PORTS, 8 <= udp_len <= total_len - IHL*4; fail -> DRAIN, drop_cnt+1.
REQ-024 On UDP pass with udp_len = 8 SHALL emit no beats, increment accept_cnt, go DRAIN.
REQ-025 On UDP pass with udp_len > 8 SHALL latch m_chan and go PAYLOAD for exactly udp_len-8 bytes.
REQ-026 m_data/m_valid SHALL be registered: byte on rx_valid at cycle N appears with m_valid=1 at N+1; m_valid=0 otherwise.
REQ-027 m_last SHALL accompany byte udp_len-8; then accept_cnt+1, state DRAIN.
REQ-028 DRAIN SHALL ignore padding/FCS bytes until rx_end or rx_start.
REQ-029 rx_end in PAYLOAD before last byte SHALL pulse m_abort next cycle, no m_last, drop_cnt+1, go IDLE.
REQ-030 rx_start during PAYLOAD SHALL pulse m_abort, drop_cnt+1, and restart parse with that byte.
REQ-031 rx_end coincident with rx_valid SHALL process the byte first; if it is the last payload byte, m_last issued, no abort.
REQ-032 rx_end in any other state SHALL go IDLE; counters SHALL hold at 0xFFFF.

Reset
REQ-033 resetn low SHALL immediately force IDLE, m_data=0, m_valid=0, m_last=0, m_chan=0, m_abort=0, accept_cnt=0, drop_cnt=0; reset mid-payload emits no abort pulse.

Verification
REQ-034 Valid frame to FPGA_MAC/FPGA_IP, port 5006, udp_len 12, payload 01 02 03 04 -> 4 beats, m_chan=1, m_last on 04, accept_cnt=1.
REQ-035 Same frame with IHL=6 (4 option bytes, correct checksum) -> identical payload delivery; corrupt one checksum bit -> no beats, drop_cnt=1.
REQ-036 Port 5009 (NUM_PORTS=4) -> no beats, drop_cnt+1; broadcast MAC with ACCEPT_BCAST=0 -> no beats, drop_cnt unchanged.
REQ-037 rx_end after 2 of 4 payload bytes -> 2 beats, m_abort pulse, no m_last, drop_cnt+1; next valid frame delivered normally.
REQ-038 udp_len 8 -> zero beats, accept_cnt+1; 60-byte padded frame with udp_len 10 -> exactly 2 beats, padding ignored.
REQ-039 resetn pulsed mid-payload -> outputs and counters 0 immediately, next frame parsed correctly.
